// File: rtl/mac_stream_scheduler_pkg.sv
// Shared FSM state type, datapath widths and helpers for the MAC stream scheduler.
package mac_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } sched_state_t;

   localparam int POSIT_W   = 32;
   localparam int TAG_DEPTH = 2;

   // Index that sits `off` places after `base` in a ring of n requesters.
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/mac_tag_fifo.sv
// Two-entry tag FIFO tracking which requester owns each outstanding MAC bank result.
module mac_tag_fifo
   import mac_sched_pkg::*;
#(
   parameter int TW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [TW-1:0] push_data,
   input  logic          pop,
   output logic [TW-1:0] pop_data,
   output logic          full,
   output logic          empty
);

   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = $clog2(TAG_DEPTH + 1);

   logic [TW-1:0]    mem_reg [TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_reg == CNT_W'(TAG_DEPTH));
   assign empty    = (count_reg == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/mac_stream_scheduler.sv
// Round-robin scheduler streaming requester dot products into one shared MAC, tagging results.
// Optional watchdog on outstanding results: define MAC_SCHED_WATCHDOG_EN.
module mac_stream_scheduler
   import mac_sched_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int WD_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*POSIT_W-1:0]   req_a,
   input  logic [NREQ*POSIT_W-1:0]   req_b,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           req_ready,
   output logic [POSIT_W-1:0]        mac_unum1,
   output logic [POSIT_W-1:0]        mac_unum2,
   output logic                      mac_valid,
   output logic                      mac_finish,
   output logic                      mac_rst,
   input  logic [POSIT_W-1:0]        mac_sum,
   input  logic                      mac_isInf,
   input  logic                      mac_overflow,
   input  logic                      mac_finish_out,
   output logic                      res_valid,
   output logic [$clog2(NREQ)-1:0]   res_id,
   output logic [POSIT_W-1:0]        res_sum,
   output logic                      res_isInf,
   output logic                      res_overflow,
   output logic                      busy,
   output logic                      wd_err
);

   localparam int TW = $clog2(NREQ);

   sched_state_t       state_reg;
   logic [TW-1:0]      grant_reg;
   logic [TW-1:0]      rr_ptr_reg;
   logic [POSIT_W-1:0] mac_unum1_reg;
   logic [POSIT_W-1:0] mac_unum2_reg;
   logic               mac_valid_reg;
   logic               mac_finish_reg;
   logic               mac_rst_reg;
   logic               res_valid_reg;
   logic [TW-1:0]      res_id_reg;
   logic [POSIT_W-1:0] res_sum_reg;
   logic               res_isinf_reg;
   logic               res_overflow_reg;

   logic [POSIT_W-1:0] a_arr    [NREQ];
   logic [POSIT_W-1:0] b_arr    [NREQ];
   logic [TW-1:0]      cand_idx [NREQ];
   logic               win_found;
   logic [TW-1:0]      win_idx;
   logic [TW-1:0]      next_rr;
   logic               grant_now;
   logic               accept;
   logic               beat_last;
   logic               pop;
   logic [TW-1:0]      pop_tag;
   logic               fifo_full;
   logic               fifo_empty;
   logic               wd_trip;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign a_arr[gi]    = req_a[gi*POSIT_W +: POSIT_W];
         assign b_arr[gi]    = req_b[gi*POSIT_W +: POSIT_W];
         assign cand_idx[gi] = TW'(rr_index(32'(rr_ptr_reg), gi, NREQ));
      end
   endgenerate

   // Scan from the far end so the candidate closest to rr_ptr wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[cand_idx[k]]) begin
            win_found = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   assign next_rr   = TW'(rr_index(32'(grant_reg), 1, NREQ));
   assign grant_now = (state_reg == IDLE) && win_found && !fifo_full && !wd_trip;
   assign accept    = (state_reg == STREAM) && req_valid[grant_reg];
   assign beat_last = req_last[grant_reg];
   assign pop       = mac_finish_out && !fifo_empty;
   assign req_ready = (state_reg == STREAM) ? (NREQ'(1) << grant_reg) : '0;
   assign busy      = (state_reg != IDLE) || !fifo_empty;

   mac_tag_fifo #(
      .TW (TW)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (wd_trip),
      .push      (grant_now),
      .push_data (win_idx),
      .pop       (pop),
      .pop_data  (pop_tag),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      mac_rst_reg <= rst;
      if (rst) begin
         state_reg        <= IDLE;
         grant_reg        <= '0;
         rr_ptr_reg       <= '0;
         mac_unum1_reg    <= '0;
         mac_unum2_reg    <= '0;
         mac_valid_reg    <= 1'b0;
         mac_finish_reg   <= 1'b0;
         res_valid_reg    <= 1'b0;
         res_id_reg       <= '0;
         res_sum_reg      <= '0;
         res_isinf_reg    <= 1'b0;
         res_overflow_reg <= 1'b0;
      end else begin
         mac_valid_reg  <= accept;
         mac_finish_reg <= accept && beat_last;
         if (accept) begin
            mac_unum1_reg <= a_arr[grant_reg];
            mac_unum2_reg <= b_arr[grant_reg];
         end
         res_valid_reg <= pop;
         if (pop) begin
            res_id_reg       <= pop_tag;
            res_sum_reg      <= mac_sum;
            res_isinf_reg    <= mac_isInf;
            res_overflow_reg <= mac_overflow;
         end
         case (state_reg)
            IDLE: begin
               if (grant_now) begin
                  grant_reg <= win_idx;
                  state_reg <= STREAM;
               end
            end
            STREAM: begin
               if (accept && beat_last) begin
                  state_reg  <= GAP;
                  rr_ptr_reg <= next_rr;
               end
            end
            GAP:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
         if (wd_trip) state_reg <= IDLE;
      end
   end

`ifdef MAC_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_reg;
   logic            wd_err_reg;

   // Trips on the WD_CYCLES-th consecutive cycle with a result outstanding and no pop.
   assign wd_trip = !fifo_empty && !pop && (wd_cnt_reg == WD_W'(WD_CYCLES - 1));
   assign wd_err  = wd_err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_reg <= '0;
         wd_err_reg <= 1'b0;
      end else begin
         if (pop || fifo_empty || wd_trip) wd_cnt_reg <= '0;
         else                              wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
         if (wd_trip) wd_err_reg <= 1'b1;
      end
   end
`else
   assign wd_trip = 1'b0;
   assign wd_err  = 1'b0;
`endif

   assign mac_unum1    = mac_unum1_reg;
   assign mac_unum2    = mac_unum2_reg;
   assign mac_valid    = mac_valid_reg;
   assign mac_finish   = mac_finish_reg;
   assign mac_rst      = mac_rst_reg;
   assign res_valid    = res_valid_reg;
   assign res_id       = res_id_reg;
   assign res_sum      = res_sum_reg;
   assign res_isInf    = res_isinf_reg;
   assign res_overflow = res_overflow_reg;

endmodule

// File: tb/tb_mac_stream_scheduler.sv
// Self-checking bench for mac_stream_scheduler: vector table, directed corner sequences, random run vs model.
module tb_mac_stream_scheduler;

   localparam int NREQ = 3;
   localparam int WD   = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    req_valid;
   logic [95:0]   req_a;
   logic [95:0]   req_b;
   logic [2:0]    req_last;
   logic [2:0]    req_ready;
   logic [31:0]   mac_unum1;
   logic [31:0]   mac_unum2;
   logic          mac_valid;
   logic          mac_finish;
   logic          mac_rst;
   logic [31:0]   mac_sum;
   logic          mac_isInf;
   logic          mac_overflow;
   logic          mac_finish_out;
   logic          res_valid;
   logic [1:0]    res_id;
   logic [31:0]   res_sum;
   logic          res_isInf;
   logic          res_overflow;
   logic          busy;
   logic          wd_err;

   always #5 clk = ~clk;

   mac_stream_scheduler #(
      .NREQ      (NREQ),
      .WD_CYCLES (WD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_last       (req_last),
      .req_ready      (req_ready),
      .mac_unum1      (mac_unum1),
      .mac_unum2      (mac_unum2),
      .mac_valid      (mac_valid),
      .mac_finish     (mac_finish),
      .mac_rst        (mac_rst),
      .mac_sum        (mac_sum),
      .mac_isInf      (mac_isInf),
      .mac_overflow   (mac_overflow),
      .mac_finish_out (mac_finish_out),
      .res_valid      (res_valid),
      .res_id         (res_id),
      .res_sum        (res_sum),
      .res_isInf      (res_isInf),
      .res_overflow   (res_overflow),
      .busy           (busy),
      .wd_err         (wd_err)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: phase 0 idle, 1 streaming, 2 gap; tagq holds outstanding owners.
   int          m_phase;
   int          m_owner;
   int          m_rr;
   int          m_age;
   int          tagq [$];
   bit          m_known = 1'b0;
   logic        e_mv, e_mf, e_mrst, e_rv, e_inf, e_ovf, e_wd;
   logic [31:0] e_u1, e_u2, e_sum;
   logic [1:0]  e_rid;

   typedef struct {
      logic [2:0] valid;
      logic [2:0] last;
      logic       fin;
      logic [2:0] ready;
      logic       mv;
      logic       mf;
      logic       rv;
      logic [1:0] rid;
      logic       busy;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic f, input logic r);
      rst            = r;
      req_valid      = v;
      req_last       = l;
      mac_finish_out = f;
      req_a          = {$urandom, $urandom, $urandom};
      req_b          = {$urandom, $urandom, $urandom};
      mac_sum        = $urandom;
      mac_isInf      = 1'($urandom_range(1));
      mac_overflow   = 1'($urandom_range(1));
   endtask

   // Called at posedge+1 with inputs applied; compares, advances model, returns at next posedge+1.
   task automatic step();
      logic [2:0] e_ready;
      logic       e_busy;
      bit         pop, acc, lst, full, trip;
      int         w;
      #1;
      if (m_known) begin
         e_ready = (m_phase == 1) ? (3'b001 << m_owner) : 3'b000;
         e_busy  = (m_phase != 0) || (tagq.size() != 0);
         check("ctrl", 128'({req_ready, mac_valid, mac_finish, mac_rst, res_valid, busy, wd_err}),
               128'({e_ready, e_mv, e_mf, e_mrst, e_rv, e_busy, e_wd}));
         check("mac_operands", 128'({mac_unum1, mac_unum2}), 128'({e_u1, e_u2}));
         check("result", 128'({res_id, res_sum, res_isInf, res_overflow}),
               128'({e_rid, e_sum, e_inf, e_ovf}));
      end
      if (rst) begin
         m_phase = 0; m_owner = 0; m_rr = 0; m_age = 0;
         tagq.delete();
         e_mv = 0; e_mf = 0; e_rv = 0; e_inf = 0; e_ovf = 0; e_wd = 0;
         e_u1 = 0; e_u2 = 0; e_sum = 0; e_rid = 0;
         e_mrst  = 1'b1;
         m_known = 1'b1;
      end else begin
         e_mrst = 1'b0;
         full   = (tagq.size() >= 2);
         pop    = mac_finish_out && (tagq.size() > 0);
         acc    = (m_phase == 1) && req_valid[m_owner];
         lst    = req_last[m_owner];
         e_mv   = acc;
         e_mf   = acc && lst;
         if (acc) begin
            e_u1 = req_a[m_owner*32 +: 32];
            e_u2 = req_b[m_owner*32 +: 32];
         end
         e_rv = pop;
         if (pop) begin
            e_rid = 2'(tagq[0]);
            e_sum = mac_sum;
            e_inf = mac_isInf;
            e_ovf = mac_overflow;
         end
         trip = 1'b0;
`ifdef MAC_SCHED_WATCHDOG_EN
         if (pop || tagq.size() == 0) m_age = 0;
         else begin
            m_age++;
            if (m_age == WD) trip = 1'b1;
         end
`endif
         if (pop) void'(tagq.pop_front());
         case (m_phase)
            0: if (!trip && !full && req_valid != 3'b000) begin
                  for (int k = 0; k < NREQ; k++) begin
                     w = (m_rr + k) % NREQ;
                     if (req_valid[w]) begin
                        m_owner = w;
                        break;
                     end
                  end
                  tagq.push_back(m_owner);
                  m_phase = 1;
               end
            1: if (acc && lst) begin
                  m_phase = 2;
                  m_rr    = (m_owner + 1) % NREQ;
               end
            default: m_phase = 0;
         endcase
         if (trip) begin
            tagq.delete();
            m_phase = 0;
            m_age   = 0;
            e_wd    = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      drive(3'b000, 3'b000, 1'b0, 1'b1);
      step();
      drive(3'b000, 3'b000, 1'b0, 1'b1);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [10];
      int          grants [$];
      int          rids [$];
      int          beats [3];
      int          exp_order [3];
      logic [2:0]  prev_ready;
      logic [2:0]  ready_seen;
      logic        busy_all;
      logic        busy_end;
      int          granted;
      int          first_wd;
      int          idle_cnt;
      logic        f;

      // Requester 0 streams 3 beats with one stall; GAP ignores req1; empty-FIFO finish_out dropped.
      tbl[0] = '{3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[1] = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
      tbl[2] = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
      tbl[3] = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
      tbl[4] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
      tbl[5] = '{3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
      tbl[6] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
      tbl[7] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
      tbl[8] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[9] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      exp_order = '{0, 1, 0};

      drive(3'b000, 3'b000, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      reset_dut();

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].valid, tbl[i].last, tbl[i].fin, 1'b0);
         #1;
         check($sformatf("vec%0d", i),
               128'({req_ready, mac_valid, mac_finish, res_valid, res_id, busy}),
               128'({tbl[i].ready, tbl[i].mv, tbl[i].mf, tbl[i].rv, tbl[i].rid, tbl[i].busy}));
         step();
      end

      // Two requesters always valid, 2-beat streams: grant order and result order 0,1,0.
      reset_dut();
      beats      = '{0, 0, 0};
      prev_ready = 3'b000;
      for (int c = 0; c < 40; c++) begin
         drive(3'b011, {1'b0, 1'(beats[1] % 2), 1'(beats[0] % 2)}, (c % 3 == 2), 1'b0);
         #1;
         if (prev_ready == 3'b000 && req_ready != 3'b000)
            grants.push_back(req_ready[1] ? 1 : (req_ready[2] ? 2 : 0));
         for (int i = 0; i < 2; i++)
            if (req_ready[i] && req_valid[i]) beats[i]++;
         if (res_valid) rids.push_back(int'(res_id));
         prev_ready = req_ready;
         step();
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("grant_order%0d", k), 128'((grants.size() > k) ? grants[k] : -1), 128'(exp_order[k]));
         check($sformatf("res_id_order%0d", k), 128'((rids.size() > k) ? rids[k] : -1), 128'(exp_order[k]));
      end

      // Two results outstanding: requester 2 must wait for a pop.
      reset_dut();
      for (int c = 0; c < 8; c++) begin
         drive(3'b011, 3'b011, 1'b0, 1'b0);
         step();
      end
      ready_seen = 3'b000;
      busy_all   = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive(3'b100, 3'b100, 1'b0, 1'b0);
         #1;
         ready_seen = ready_seen | req_ready;
         busy_all   = busy_all & busy;
         step();
      end
      check("full_fifo_blocks_grant", 128'(ready_seen), 128'(3'b000));
      check("full_fifo_busy", 128'(busy_all), 128'(1'b1));
      drive(3'b100, 3'b100, 1'b1, 1'b0);
      step();
      granted = -1;
      for (int c = 0; c < 6; c++) begin
         drive(3'b100, 3'b100, 1'b0, 1'b0);
         #1;
         if (req_ready[2] && granted < 0) granted = c;
         step();
      end
      check("grant_after_pop_latency", 128'(granted), 128'(1));
      for (int c = 0; c < 4; c++) begin
         drive(3'b000, 3'b000, 1'b1, 1'b0);
         step();
      end

      // Reset in the middle of a stream after two beats.
      reset_dut();
      for (int c = 0; c < 3; c++) begin
         drive(3'b001, 3'b000, 1'b0, 1'b0);
         step();
      end
      drive(3'b001, 3'b000, 1'b0, 1'b1);
      step();
      drive(3'b000, 3'b000, 1'b0, 1'b0);
      #1;
      check("midstream_rst_state", 128'({mac_rst, req_ready, busy}), 128'({1'b1, 3'b000, 1'b0}));
      step();
      drive(3'b000, 3'b000, 1'b1, 1'b0);
      step();
      drive(3'b000, 3'b000, 1'b0, 1'b0);
      #1;
      check("abandoned_no_result", 128'(res_valid), 128'(1'b0));
      step();

      // Withheld finish_out: watchdog trips 65 cycles after the grant cycle when enabled.
      reset_dut();
      drive(3'b001, 3'b001, 1'b0, 1'b0);
      step();
      drive(3'b001, 3'b001, 1'b0, 1'b0);
      step();
      first_wd = -1;
      busy_end = 1'b0;
      for (int c = 2; c < 90; c++) begin
         drive(3'b000, 3'b000, 1'b0, 1'b0);
         #1;
         if (wd_err && first_wd < 0) first_wd = c;
         busy_end = busy;
         step();
      end
`ifdef MAC_SCHED_WATCHDOG_EN
      check("wd_trip_cycle", 128'(first_wd), 128'(65));
      check("wd_flush_idle", 128'({wd_err, busy_end}), 128'({1'b1, 1'b0}));
`else
      check("wd_never_trips", 128'(first_wd), 128'(-1));
      check("wd_disabled_busy", 128'({wd_err, busy_end}), 128'({1'b0, 1'b1}));
`endif
      reset_dut();

      // Random traffic against the model.
      idle_cnt = 0;
      for (int c = 0; c < 2500; c++) begin
         f = ($urandom_range(3) == 0) || (idle_cnt > 40);
         drive(3'($urandom_range(7)), 3'($urandom_range(7)) & 3'($urandom_range(7)), f,
               ($urandom_range(299) == 0));
         step();
         if (tagq.size() > 0 && !f) idle_cnt++;
         else idle_cnt = 0;
      end

      drive(3'b000, 3'b000, 1'b0, 1'b0);
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mac_stream_scheduler.md
MAC_STREAM_SCHEDULER -- requirements
Module: mac_stream_scheduler

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one multiply_accumulator instance (2..8).
REQ-002 Parameter WD_CYCLES, default 64: watchdog limit in cycles for an outstanding result.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high, rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester operand beat valid.
REQ-007 req_a, req_b  in  NREQ*32 each  posit32 operand pairs; slice i belongs to requester i.
REQ-008 req_last  in  NREQ  beat is final product of requester's dot product.
REQ-009 req_ready  out  NREQ  per-requester beat accept.
REQ-010 mac_unum1, mac_unum2  out  32 each  operands to MAC.
REQ-011 mac_valid, mac_finish, mac_rst  out  1 each  MAC valid, end-of-accumulation and reset strobes.
REQ-012 mac_sum  in  32;  mac_isInf, mac_overflow, mac_finish_out  in  1 each  MAC result bus.
REQ-013 res_valid  out  1;  res_id  out  clog2(NREQ);  res_sum  out  32;  res_isInf, res_overflow  out  1 each  tagged result.
REQ-014 busy  out  1  state != IDLE or results outstanding;  wd_err  out  1  sticky watchdog error.

Function
REQ-015 FSM states IDLE, STREAM, GAP; reset state IDLE.
REQ-016 IDLE: if any req_valid and tag FIFO not full, grant round-robin winner (lowest index >= rr_ptr with req_valid, wrapping), push its index into tag FIFO, go STREAM next cycle.
REQ-017 req_ready[i] SHALL be combinational, high only in STREAM with grant==i; a beat is accepted on req_valid[i]&req_ready[i].
REQ-018 Each accepted beat drives mac_unum1/2 = req_a/b slice, mac_valid=1 one cycle later (registered, latency 1); otherwise mac_valid=0, operands hold.
REQ-019 Accepted beat with req_last=1 SHALL also drive mac_finish=1 in the same output cycle; FSM goes GAP, rr_ptr = (grant+1) mod NREQ.
REQ-020 GAP lasts exactly one cycle (MAC bank switch), then IDLE; no grant in GAP.
REQ-021 Tag FIFO depth 2 (MAC ping-pong banks); IDLE SHALL not grant while 2 results outstanding.
REQ-022 On mac_finish_out=1: pop tag; next cycle res_valid=1 for one cycle with res_id=popped tag, res_sum/res_isInf/res_overflow registered from MAC inputs.
REQ-023 mac_finish_out with empty FIFO is discarded: no res_valid, no state change.
REQ-024 Push (grant) and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-025 Requester deasserting req_valid mid-stream: grant held, no beats issued, no timeout on stream side.

Reset
REQ-026 On rst: state IDLE, rr_ptr 0, FIFO empty, watchdog 0, wd_err 0, all outputs 0 except mac_rst.
REQ-027 mac_rst SHALL be rst registered once (high the cycle after rst high); reset mid-stream abandons the stream, no result emitted for it.

Configuration
REQ-028 Macro MAC_SCHED_WATCHDOG_EN defined: counter increments each cycle FIFO non-empty, clears on pop; at WD_CYCLES sets wd_err, flushes FIFO, forces IDLE; only rst clears wd_err.
REQ-029 Macro undefined: no counter logic, wd_err tied 0, port retained.

Structure
REQ-030 Package mac_sched_pkg SHALL hold FSM state enum, posit width constant (32) and FIFO depth constant (2).
REQ-031 Tag FIFO SHALL be sub-module mac_tag_fifo (depth 2, width clog2(NREQ), full/empty flags).

Verification
REQ-032 Req0 sends 3 beats, last on 3rd -> 3 mac_valid pulses, mac_finish with 3rd, GAP 1 cycle; mac_finish_out -> res_valid, res_id=0.
REQ-033 Req0 and req1 valid continuously, 2-beat streams -> grants alternate 0,1,0; res_id order matches grant order.
REQ-034 Two streams finished, no mac_finish_out -> third requester not granted until a mac_finish_out pops.
REQ-035 rst asserted mid-stream after 2 beats -> next cycle mac_rst=1, req_ready=0, busy=0, later mac_finish_out produces no res_valid.
REQ-036 MAC_SCHED_WATCHDOG_EN, WD_CYCLES=64, mac_finish_out withheld -> wd_err=1 after 64 outstanding cycles, FIFO empty, state IDLE; without macro wd_err stays 0.
